// File: rtl/wallace_mac.sv
// Pipelined Wallace-tree multiply-accumulate with per-beat signed/unsigned mode and framed window sums.
// Latency: product 3 clocks, window sum 4 clocks after the closing beat's input edge.
// No backpressure: the pipeline advances every cycle and accepts one operand pair per clock.
module wallace_mac #(
    parameter int WIDTH     = 8,
    parameter int ACC_GUARD = 4,
    localparam int PW        = 2 * WIDTH,
    localparam int ACC_WIDTH = PW + ACC_GUARD
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic                 is_signed,
    input  logic                 first,
    input  logic                 last,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [PW-1:0]        product,
    output logic                 product_valid,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    output logic                 overflow
);

    // Partial-product rows plus one correction row; two spare slots keep the
    // compressor indexing in range without special-casing the tail.
    localparam int NROWS = WIDTH + 1;
    localparam int NSLOT = NROWS + 2;

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] LOW_MASK = ~MSB_MASK;
    // Baugh-Wooley correction: +2^W and +2^(2W-1), taken modulo 2^(2W).
    localparam logic [PW-1:0]    BW_CORR  = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    // S1 state
    logic [WIDTH-1:0] x_q, y_q;
    logic             sgn1_q, first1_q, last1_q, vld1_q;
    // S2 state
    logic [PW-1:0]    sum_q, carry_q;
    logic             sgn2_q, first2_q, last2_q, vld2_q;
    // S3 control travelling alongside product
    logic             sgn3_q, first3_q, last3_q;
    // Accumulator state
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic [PW-1:0]        pp   [NSLOT];
    logic [PW-1:0]        tree [NSLOT];
    logic [ACC_WIDTH-1:0] ext_w, base_w;
    logic [ACC_WIDTH:0]   sum_w;
    logic                 beat_ovf_w;

    // S1: capture the operand beat and its framing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            sgn1_q   <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            vld1_q   <= 1'b0;
        end else begin
            x_q      <= x;
            y_q      <= y;
            sgn1_q   <= is_signed;
            first1_q <= first;
            last1_q  <= last;
            vld1_q   <= in_valid;
        end
    end

    // Partial products; signed mode inverts the terms that pair exactly one sign bit
    always_comb begin
        logic [WIDTH-1:0] row;
        for (int r = 0; r < NSLOT; r++) begin
            pp[r] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            row = x_q & {WIDTH{y_q[i]}};
            if (sgn1_q) begin
                row = row ^ ((i == WIDTH - 1) ? LOW_MASK : MSB_MASK);
            end
            pp[i] = {{WIDTH{1'b0}}, row} << i;
        end
        pp[WIDTH] = sgn1_q ? BW_CORR : '0;
    end

    // Wallace reduction: each level compresses row triples 3:2 and leftover pairs 2:2
    always_comb begin
        logic [PW-1:0] nxt [NSLOT];
        int n;
        int m;
        tree = pp;
        n    = NROWS;
        for (int lvl = 0; lvl < NROWS; lvl++) begin
            if (n > 2) begin
                for (int r = 0; r < NSLOT; r++) begin
                    nxt[r] = '0;
                end
                m = 0;
                for (int k = 0; k < NROWS; k += 3) begin
                    if (k + 2 < n) begin
                        nxt[m]     = tree[k] ^ tree[k+1] ^ tree[k+2];
                        nxt[m+1]   = ((tree[k] & tree[k+1]) | (tree[k] & tree[k+2]) |
                                      (tree[k+1] & tree[k+2])) << 1;
                        m          = m + 2;
                    end else if (k + 1 < n) begin
                        nxt[m]     = tree[k] ^ tree[k+1];
                        nxt[m+1]   = (tree[k] & tree[k+1]) << 1;
                        m          = m + 2;
                    end else if (k < n) begin
                        nxt[m]     = tree[k];
                        m          = m + 1;
                    end
                end
                tree = nxt;
                n    = m;
            end
        end
    end

    // S2: register the two carry-save rows
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_q    <= '0;
            carry_q  <= '0;
            sgn2_q   <= 1'b0;
            first2_q <= 1'b0;
            last2_q  <= 1'b0;
            vld2_q   <= 1'b0;
        end else begin
            sum_q    <= tree[0];
            carry_q  <= tree[1];
            sgn2_q   <= sgn1_q;
            first2_q <= first1_q;
            last2_q  <= last1_q;
            vld2_q   <= vld1_q;
        end
    end

    // S3: carry-propagate add; product holds across invalid cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            product       <= '0;
            product_valid <= 1'b0;
            sgn3_q        <= 1'b0;
            first3_q      <= 1'b0;
            last3_q       <= 1'b0;
        end else begin
            if (vld2_q) begin
                product <= sum_q + carry_q;
            end
            product_valid <= vld2_q;
            sgn3_q        <= sgn2_q;
            first3_q      <= first2_q;
            last3_q       <= last2_q;
        end
    end

    // Next accumulator value and overflow, judged in the current beat's mode
    always_comb begin
        ext_w  = sgn3_q ? {{ACC_GUARD{product[PW-1]}}, product} : {{ACC_GUARD{1'b0}}, product};
        base_w = first3_q ? '0 : acc_q;
        sum_w  = {1'b0, base_w} + {1'b0, ext_w};
        if (sgn3_q) begin
            beat_ovf_w = (base_w[ACC_WIDTH-1] == ext_w[ACC_WIDTH-1]) &&
                         (sum_w[ACC_WIDTH-1] != base_w[ACC_WIDTH-1]);
        end else begin
            beat_ovf_w = sum_w[ACC_WIDTH];
        end
        acc_d = sum_w[ACC_WIDTH-1:0];
        ovf_d = (ovf_q & ~first3_q) | beat_ovf_w;
    end

    // Accumulate valid products; publish the sum and sticky overflow on the closing beat
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            acc_valid <= product_valid & last3_q;
            if (product_valid) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
                if (last3_q) begin
                    acc_out  <= acc_d;
                    overflow <= ovf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_wallace_mac.sv
// Bench for wallace_mac at WIDTH 4, 8 and 16 driven in lockstep.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled on the falling edge.
// A cycle-indexed arithmetic model predicts every output; directed windows also pin literal results.
module tb_wallace_mac;

    localparam int SL = 64;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        in_valid, is_signed, first, last;
    logic [3:0]  x4, y4;
    logic [7:0]  x8, y8;
    logic [15:0] x16, y16;

    logic [7:0]  p4;  logic pv4;  logic [11:0] acc4;  logic av4;  logic ov4;
    logic [15:0] p8;  logic pv8;  logic [19:0] acc8;  logic av8;  logic ov8;
    logic [31:0] p16; logic pv16; logic [35:0] acc16; logic av16; logic ov16;

    wallace_mac #(.WIDTH(4)) u_w4 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .is_signed(is_signed),
        .first(first), .last(last), .x(x4), .y(y4), .product(p4), .product_valid(pv4),
        .acc_out(acc4), .acc_valid(av4), .overflow(ov4));
    wallace_mac #(.WIDTH(8)) u_w8 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .is_signed(is_signed),
        .first(first), .last(last), .x(x8), .y(y8), .product(p8), .product_valid(pv8),
        .acc_out(acc8), .acc_valid(av8), .overflow(ov8));
    wallace_mac #(.WIDTH(16)) u_w16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .is_signed(is_signed),
        .first(first), .last(last), .x(x16), .y(y16), .product(p16), .product_valid(pv16),
        .acc_out(acc16), .acc_valid(av16), .overflow(ov16));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- arithmetic reference ----------------
    function automatic int wof(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 8 : 16);
    endfunction

    function automatic longint mk(input int bits);
        return (longint'(1) << bits) - 1;
    endfunction

    function automatic longint sx(input longint v, input int bits);
        if (v[bits-1]) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic longint mulx(input int w, input bit s, input longint a, input longint b);
        longint av, bv;
        av = s ? sx(a, w) : a;
        bv = s ? sx(b, w) : b;
        return (av * bv) & mk(2 * w);
    endfunction

    function automatic longint opx(input int d);
        return (d == 0) ? longint'(x4) : ((d == 1) ? longint'(x8) : longint'(x16));
    endfunction

    function automatic longint opy(input int d);
        return (d == 0) ? longint'(y4) : ((d == 1) ? longint'(y8) : longint'(y16));
    endfunction

    // Expected outputs, indexed by the rising-edge count after which they must appear
    bit     e_pv  [3][SL];
    longint e_p   [3][SL];
    bit     e_av  [3][SL];
    longint e_acc [3][SL];
    bit     e_ov  [3][SL];
    longint accm  [3];
    bit     ovm   [3];
    longint hp    [3];
    longint ha    [3];
    int     cyc = 0;

    longint obs_p [$];
    longint obs_a [$];
    longint obs_o [$];

    // Model: a beat sampled at edge s shows its product after edge s+2 and its window sum after s+3
    always @(posedge clock) begin
        int w, a;
        longint p, v, base, t;
        bit o;
        cyc++;
        if (!reset_n) begin
            for (int d = 0; d < 3; d++) begin
                accm[d] = 0;
                ovm[d]  = 1'b0;
                for (int s = 0; s < SL; s++) begin
                    e_pv[d][s] = 1'b0;
                    e_av[d][s] = 1'b0;
                end
            end
        end else if (in_valid) begin
            for (int d = 0; d < 3; d++) begin
                w = wof(d);
                a = 2 * w + 4;
                p = mulx(w, is_signed, opx(d), opy(d));
                e_pv[d][(cyc + 2) % SL] = 1'b1;
                e_p[d][(cyc + 2) % SL]  = p;
                v    = is_signed ? (sx(p, 2 * w) & mk(a)) : p;
                base = first ? 0 : accm[d];
                if (is_signed) begin
                    t = sx(base, a) + sx(v, a);
                    o = (t > mk(a - 1)) || (t < -(mk(a - 1) + 1));
                end else begin
                    o = (base + v) > mk(a);
                end
                accm[d] = (base + v) & mk(a);
                ovm[d]  = (first ? 1'b0 : ovm[d]) | o;
                if (last) begin
                    e_av[d][(cyc + 3) % SL]  = 1'b1;
                    e_acc[d][(cyc + 3) % SL] = accm[d];
                    e_ov[d][(cyc + 3) % SL]  = ovm[d];
                end
            end
        end
    end

    // Compare every DUT output against the model on every cycle
    always @(negedge clock) begin
        longint apv, ap, aav, aacc, aov;
        int s, w;
        s = cyc % SL;
        for (int d = 0; d < 3; d++) begin
            w = wof(d);
            case (d)
                0:       begin apv = pv4;  ap = p4;  aav = av4;  aacc = acc4;  aov = ov4;  end
                1:       begin apv = pv8;  ap = p8;  aav = av8;  aacc = acc8;  aov = ov8;  end
                default: begin apv = pv16; ap = p16; aav = av16; aacc = acc16; aov = ov16; end
            endcase
            if (!reset_n) begin
                hp[d] = 0;
                ha[d] = 0;
                chk($sformatf("rst_pv_w%0d", w), apv, 0);
                chk($sformatf("rst_av_w%0d", w), aav, 0);
                chk($sformatf("rst_p_w%0d", w), ap, 0);
                chk($sformatf("rst_acc_w%0d", w), aacc, 0);
                chk($sformatf("rst_ov_w%0d", w), aov, 0);
            end else begin
                if (e_pv[d][s]) hp[d] = e_p[d][s];
                chk($sformatf("pv_w%0d_c%0d", w, cyc), apv, longint'(e_pv[d][s]));
                chk($sformatf("p_w%0d_c%0d", w, cyc), ap, hp[d]);
                chk($sformatf("av_w%0d_c%0d", w, cyc), aav, longint'(e_av[d][s]));
                if (e_av[d][s]) begin
                    ha[d] = e_acc[d][s];
                    chk($sformatf("ov_w%0d_c%0d", w, cyc), aov, longint'(e_ov[d][s]));
                end
                chk($sformatf("acc_w%0d_c%0d", w, cyc), aacc, ha[d]);
                if (d == 1) begin
                    if (pv8) obs_p.push_back(longint'(p8));
                    if (av8) begin
                        obs_a.push_back(longint'(acc8));
                        obs_o.push_back(longint'(ov8));
                    end
                end
                e_pv[d][s] = 1'b0;
                e_av[d][s] = 1'b0;
            end
        end
    end

    function automatic longint pget(input int i);
        return (i < obs_p.size()) ? obs_p[i] : -1;
    endfunction
    function automatic longint aget(input int i);
        return (i < obs_a.size()) ? obs_a[i] : -1;
    endfunction
    function automatic longint oget(input int i);
        return (i < obs_o.size()) ? obs_o[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit s, input bit f, input bit l,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid  = v;
        is_signed = s;
        first     = f;
        last      = l;
        x8        = a;
        y8        = b;
        x4        = 4'($urandom);
        y4        = 4'($urandom);
        x16       = 16'($urandom);
        y16       = 16'($urandom);
        @(posedge clock);
        #1;
    endtask

    // Bubbles carry random framing to show first/last are ignored without in_valid
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endtask

    task automatic clr();
        obs_p.delete();
        obs_a.delete();
        obs_o.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; is_signed = 1'b0; first = 1'b0; last = 1'b0;
        x4 = '0; y4 = '0; x8 = '0; y8 = '0; x16 = '0; y16 = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Beat without first straight after reset accumulates onto zero: 3*5
        clr();
        drive(1, 0, 0, 1, 8'h03, 8'h05);
        idle(6);
        chk("nofirst_cnt", obs_a.size(), 1);
        chk("nofirst_acc", aget(0), 'h0000F);

        // Unsigned single-beat windows
        clr();
        drive(1, 0, 1, 1, 8'hAA, 8'h55);
        drive(1, 0, 1, 1, 8'hAF, 8'h5D);
        drive(1, 0, 1, 1, 8'hEA, 8'h50);
        idle(6);
        chk("u_cnt", obs_p.size(), 3);
        chk("u_p0", pget(0), 'h3872);
        chk("u_p1", pget(1), 'h3F93);
        chk("u_p2", pget(2), 'h4920);
        chk("u_a0", aget(0), 'h03872);
        chk("u_a1", aget(1), 'h03F93);
        chk("u_a2", aget(2), 'h04920);
        chk("u_o2", oget(2), 0);

        // Signed single-beat windows
        clr();
        drive(1, 1, 1, 1, 8'hAA, 8'h55);
        drive(1, 1, 1, 1, 8'h80, 8'h80);
        drive(1, 1, 1, 1, 8'h80, 8'h7F);
        idle(6);
        chk("s_p0", pget(0), 'hE372);
        chk("s_p1", pget(1), 'h4000);
        chk("s_p2", pget(2), 'hC080);
        chk("s_a0", aget(0), 'hFE372);
        chk("s_a2", aget(2), 'hFC080);
        chk("s_o2", oget(2), 0);

        // Three-beat window with a bubble after the opening beat
        clr();
        drive(1, 0, 1, 0, 8'hAA, 8'h55);
        idle(1);
        drive(1, 0, 0, 0, 8'hAF, 8'h5D);
        drive(1, 0, 0, 1, 8'hEA, 8'h50);
        idle(6);
        chk("win_cnt", obs_a.size(), 1);
        chk("win_acc", aget(0), 'h0C125);
        chk("win_ov", oget(0), 0);

        // 16 and 17 beats of 0xFF*0xFF back to back, then an immediate clean window
        clr();
        for (int i = 0; i < 16; i++) drive(1, 0, i == 0, i == 15, 8'hFF, 8'hFF);
        for (int i = 0; i < 17; i++) drive(1, 0, i == 0, i == 16, 8'hFF, 8'hFF);
        drive(1, 0, 1, 1, 8'h01, 8'h02);
        idle(6);
        chk("ovf_cnt", obs_a.size(), 3);
        chk("ovf16_acc", aget(0), 'hFE010);
        chk("ovf16_ov", oget(0), 0);
        chk("ovf17_acc", aget(1), 'h0DE11);
        chk("ovf17_ov", oget(1), 1);
        chk("ovf_next_acc", aget(2), 'h00002);
        chk("ovf_next_ov", oget(2), 0);

        // A second first restarts the window: only 2*3 + 1*1 survives
        clr();
        drive(1, 0, 1, 0, 8'h0A, 8'h0A);
        drive(1, 0, 1, 0, 8'h02, 8'h03);
        drive(1, 0, 0, 1, 8'h01, 8'h01);
        idle(6);
        chk("restart_cnt", obs_a.size(), 1);
        chk("restart_acc", aget(0), 'h00007);

        // Reset for one cycle during beat 2; next window opens two cycles after release
        clr();
        drive(1, 0, 1, 0, 8'h03, 8'h03);
        reset_n = 1'b0;
        drive(1, 0, 0, 0, 8'h04, 8'h04);
        reset_n = 1'b1;
        idle(1);
        drive(1, 0, 1, 0, 8'h02, 8'h02);
        drive(1, 0, 0, 0, 8'h05, 8'h05);
        drive(1, 0, 0, 1, 8'h07, 8'h07);
        idle(6);
        chk("rst_pcnt", obs_p.size(), 3);
        chk("rst_p0", pget(0), 'h0004);
        chk("rst_acnt", obs_a.size(), 1);
        chk("rst_acc", aget(0), 'h0004E);

        // Random sweep across all widths, modes and framings
        repeat (400) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
                  8'($urandom), 8'($urandom));
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
